// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and legal stop-bit lengths.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int START_MID  = 7;

   localparam int SB_TICK_1   = 16;
   localparam int SB_TICK_1P5 = 24;
   localparam int SB_TICK_2   = 32;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_RX_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP,
      RX_BREAK
   } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
// Reusable for any asynchronous pin that must enter the clk domain.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x-oversampled start/data/stop recovery with break protection.
// Optional even parity is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = SB_TICK_1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            parity_err,
   output logic            busy
);

   localparam int NW = $clog2(DBIT);

   localparam logic [5:0]    S_START_MID = 6'(START_MID);
   localparam logic [5:0]    S_BIT_LAST  = 6'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
   // Unsupported SB_TICK values fall back to a single stop bit.
   localparam logic [5:0]    S_STOP_LAST =
      (SB_TICK == SB_TICK_2)   ? 6'(SB_TICK_2 - 1)   :
      (SB_TICK == SB_TICK_1P5) ? 6'(SB_TICK_1P5 - 1) :
                                 6'(SB_TICK_1 - 1);

   logic rx_s;

   rx_state_e       state_q,      state_d;
   logic [5:0]      s_q,          s_d;
   logic [NW-1:0]   n_q,          n_d;
   logic [DBIT-1:0] b_q,          b_d;
   logic [DBIT-1:0] dout_q,       dout_d;
   logic            frame_err_q,  frame_err_d;
   logic            rx_done_q,    rx_done_d;
`ifdef UART_RX_PARITY_EN
   logic            par_bad_q,    par_bad_d;
   logic            parity_err_q, parity_err_d;
`endif

   uart_sync2 #(
      .RESET_VAL(1'b1)
   ) u_rx_sync (
      .clk(clk),
      .rst(rst),
      .d  (rx),
      .q  (rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RX_IDLE;
         s_q          <= '0;
         n_q          <= '0;
         b_q          <= '0;
         dout_q       <= '0;
         frame_err_q  <= 1'b0;
         rx_done_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         n_q          <= n_d;
         b_q          <= b_d;
         dout_q       <= dout_d;
         frame_err_q  <= frame_err_d;
         rx_done_q    <= rx_done_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // A tick that coincides with a state change is consumed by that change, never counted again.
   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      n_d          = n_q;
      b_d          = b_q;
      dout_d       = dout_q;
      frame_err_d  = frame_err_q;
      rx_done_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = parity_err_q;
`endif

      case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               state_d = RX_START;
               s_d     = '0;
            end
         end

         RX_START: begin
            if (s_tick) begin
               if (s_q == S_START_MID) begin
                  if (!rx_s) begin
                     state_d = RX_DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = RX_IDLE;
                  end
               end else begin
                  s_d = s_q + 6'd1;
               end
            end
         end

         RX_DATA: begin
            if (s_tick) begin
               if (s_q == S_BIT_LAST) begin
                  s_d = '0;
                  b_d = {rx_s, b_q[DBIT-1:1]};
                  n_d = n_q + NW'(1);
                  if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = RX_PARITY;
`else
                     state_d = RX_STOP;
`endif
                  end
               end else begin
                  s_d = s_q + 6'd1;
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         RX_PARITY: begin
            if (s_tick) begin
               if (s_q == S_BIT_LAST) begin
                  par_bad_d = (^b_q) ^ rx_s;
                  s_d       = '0;
                  state_d   = RX_STOP;
               end else begin
                  s_d = s_q + 6'd1;
               end
            end
         end
`endif

         RX_STOP: begin
            if (s_tick) begin
               if (s_q == S_STOP_LAST) begin
                  dout_d      = b_q;
                  frame_err_d = ~rx_s;
                  rx_done_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_err_d = par_bad_q;
`endif
                  state_d = rx_s ? RX_IDLE : RX_BREAK;
               end else begin
                  s_d = s_q + 6'd1;
               end
            end
         end

         // A held-low line must go high before another start bit can be recognised.
         RX_BREAK: begin
            if (rx_s) begin
               state_d = RX_IDLE;
            end
         end

         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   assign dout         = dout_q;
   assign rx_done_tick = rx_done_q;
   assign frame_err    = frame_err_q;
   assign busy         = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err   = parity_err_q;
`else
   assign parity_err   = 1'b0;
`endif

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

- Serial-to-parallel receive deframer for the UART.
- Recovers one asynchronous frame from the `rx` line: start bit, DBIT data bits LSB first, optional even parity, and SB_TICK/16 stop bits.
- Uses the shared 16x-oversampling baud tick from the baud-rate generator.
- Sits between the `rx` pin and the receive FIFO. It is the counterpart of the transmit serializer driving `tx`.

## Interface
- `DBIT`, default 8: data bits per frame, legal range 5–9.
- `SB_TICK`, default 16: stop-bit duration in oversampling ticks. Legal values are 16, 24 and 32, for 1, 1.5 and 2 stop bits.
- `clk`  in  1: system clock. Only one clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `s_tick`  in  1: one-cycle enable pulse at 16x the baud rate, from the baud generator.
- `rx`  in  1: asynchronous serial line; idles high.
- `dout`  out  DBIT: received data word. Holds its value until the next frame completes.
- `rx_done_tick`  out  1: one-cycle pulse when `dout` and the error flags update. Serves as the FIFO write strobe.
- `frame_err`  out  1: stop bit sampled low. Valid with `rx_done_tick` and held until the next frame.
- `parity_err`  out  1: parity mismatch. Valid with `rx_done_tick`. Tied to 0 when parity is compiled out.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value `rx_s`.
- Counters:
  - `s`: tick counter, 6 bits, counts `s_tick` pulses only.
  - `n`: bit counter, width clog2(DBIT).
  - `b`: DBIT-bit shift register.
- IDLE:
  - On `rx_s`=0, go to START and clear `s`.
  - This check does not require `s_tick`.
- START:
  - On each `s_tick`, increment `s`.
  - At `s`=7 (mid start bit):
    - If `rx_s`=0: go to DATA and clear `s` and `n`.
    - If `rx_s`=1: glitch. Return to IDLE with no output pulse.
- DATA:
  - At `s`=15 on `s_tick`: shift `b` right with `rx_s` entering the MSB, clear `s`, increment `n`.
  - After bit DBIT-1, go to PARITY if enabled, otherwise to STOP.
- PARITY:
  - At `s`=15, sample `rx_s`, store `par_bad = ^b ^ rx_s` (even parity), clear `s`, go to STOP.
- STOP:
  - At `s`=SB_TICK-1, load `dout<=b`, `frame_err<=~rx_s`, `parity_err<=par_bad`, and pulse `rx_done_tick`.
  - If `rx_s`=1, go to IDLE. Otherwise go to BREAK.
- BREAK:
  - Line held low (break or misframe).
  - Stay here, ignoring start detection, until `rx_s`=1, then go to IDLE.
  - Prevents a continuous low line from producing repeated bogus frames.
- Reset mid-frame: the partial frame is discarded. No `rx_done_tick` is generated.

## Timing
- Reset values:
  - `dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - State IDLE; `s`=0, `n`=0, `b`=0; synchronizer flops 1.
- Line-to-logic latency is 2 `clk` cycles through the synchronizer.
- Start-bit falling edge to `busy`=1: 3 cycles.
- `rx_done_tick` is registered. It asserts in the cycle after the `clk` edge that consumes the final stop `s_tick`, and is exactly 1 cycle wide even if `s_tick` is held high.
- Frame duration is 8 + 16·DBIT (+16 with parity) + SB_TICK ticks after start detect. `rx_done_tick` occurs near mid stop bit.
- The block accepts a new start edge on the cycle after returning to IDLE. Back-to-back frames need no idle gap.
- `s_tick` high together with a state transition: the transition consumes that tick. No tick is counted twice.
- No handshake or backpressure exists. The consumer must capture `dout` on `rx_done_tick`. Overflow handling belongs to the FIFO.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state and `par_bad` register are compiled in.
  - Frames carry one even-parity bit after the data.
  - `parity_err` is live.
- Not defined:
  - DATA goes directly to STOP.
  - `parity_err` is constant 0 and the PARITY state encoding is absent.

## Structure
- Shared package `uart_pkg` holds:
  - the receiver state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `OVERSAMPLE`=16 and `START_MID`=7;
  - legal SB_TICK constants.
- One sub-module, `uart_sync2`: a 2-flop synchronizer with a reset value parameter. It is reusable for other asynchronous inputs.

## Test plan
All scenarios use DBIT=8, SB_TICK=16, and `s_tick` every 10 clk.
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1 → one `rx_done_tick`, `dout`=0xA5, `frame_err`=0, `busy` low 1 cycle after the pulse.
- 3-tick low glitch on idle `rx` → no `rx_done_tick`, state back to IDLE, `dout` unchanged.
- Frame 0x3C with stop bit forced 0, then line held low for 40 ticks → single `rx_done_tick` with `frame_err`=1, no further pulses until `rx` returns high.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two pulses, `dout`=0x00 then 0xFF, both with `frame_err`=0.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → `parity_err`=0; 0x07 with parity bit 0 → `parity_err`=1.
- `rst` asserted during data bit 4 of a frame → all outputs 0 the next cycle, no pulse; a following 0x5A frame is received correctly.
